sar_search: RTL

Sequential successive-approximation searcher; the initiator side of the team's 8-bit magnitude comparator interface.
- Drives the comparator's B operand (probe) one trial value per cycle.
- Consumes the comparator's gt/eq/lt flags and resolves, MSB first, the unknown value held on the comparator's A side.
- Used for threshold/level capture: software pulses start and reads result/found when done pulses.

---
 rtl/sar_search_pkg.sv | 21 ++
 rtl/sar_search_cmp8.sv | 42 ++++
 rtl/sar_search.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation searcher: FSM states and flag legality.
// Pure declarations; no timing or flow-control behaviour of its own.
package sar_search_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STEP   = 2'd1,
      VERIFY = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Flag vector order is {gt, eq, lt}; a healthy comparator asserts exactly one.
   localparam logic [2:0] FLAG_GT = 3'b100;
   localparam logic [2:0] FLAG_EQ = 3'b010;
   localparam logic [2:0] FLAG_LT = 3'b001;

   function automatic logic flags_valid(input logic [2:0] flags);
      return (flags == FLAG_GT) || (flags == FLAG_EQ) || (flags == FLAG_LT);
   endfunction

endpackage

// File: rtl/sar_search_cmp8.sv
// Integration wrapper: sar_search paired with an 8-bit magnitude comparator (A = ext_val, B = probe).
// Latency as sar_search; start ignored while busy, no backpressure.
module sar_search_cmp8 #(
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] ext_val,
   output logic [7:0] probe,
   output logic       busy,
   output logic       done,
   output logic [7:0] result,
   output logic       found,
   output logic       err
);

   logic cmp_gt, cmp_eq, cmp_lt;

   assign cmp_gt = (ext_val > probe);
   assign cmp_eq = (ext_val == probe);
   assign cmp_lt = (ext_val < probe);

   sar_search #(
      .WIDTH      (8),
      .EARLY_EXIT (EARLY_EXIT)
   ) u_search (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .cmp_gt (cmp_gt),
      .cmp_eq (cmp_eq),
      .cmp_lt (cmp_lt),
      .probe  (probe),
      .busy   (busy),
      .done   (done),
      .result (result),
      .found  (found),
      .err    (err)
   );

endmodule

// File: rtl/sar_search.sv
// MSB-first successive-approximation search driving a comparator probe, one bit per cycle.
// Latency WIDTH+2 cycles start-to-done (less on early exit); start ignored while busy, no backpressure.
module sar_search
   import sar_search_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cmp_gt,
   input  logic             cmp_eq,
   input  logic             cmp_lt,
   output logic [WIDTH-1:0] probe,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             found,
   output logic             err
);

   localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] probe_q, probe_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             found_q, found_d;
   logic             err_q, err_d;

   logic             flags_ok;
   logic [WIDTH-1:0] new_acc;
   logic [IDXW-1:0]  idx_dec;
   logic [WIDTH-1:0] bit_mask;

   always_comb begin
      state_d  = state_q;
      probe_d  = probe_q;
      acc_d    = acc_q;
      result_d = result_q;
      idx_d    = idx_q;
      found_d  = found_q;
      err_d    = err_q;

      flags_ok = flags_valid({cmp_gt, cmp_eq, cmp_lt});
      // A trial at or below the hidden value keeps its bit.
      new_acc  = (cmp_gt | cmp_eq) ? probe_q : acc_q;
      idx_dec  = idx_q - IDXW'(1);
      bit_mask = WIDTH'(1) << idx_dec;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               acc_d   = '0;
               idx_d   = IDXW'(WIDTH - 1);
               probe_d = {1'b1, {(WIDTH-1){1'b0}}};
               found_d = 1'b0;
               err_d   = 1'b0;
               state_d = STEP;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         STEP: begin
            if (!flags_ok) begin
               err_d    = 1'b1;
               found_d  = 1'b0;
               result_d = acc_q;
               state_d  = DONE;
            end else begin
               acc_d = new_acc;
               if (EARLY_EXIT && cmp_eq) begin
                  result_d = probe_q;
                  found_d  = 1'b1;
                  state_d  = DONE;
               end else if (idx_q != '0) begin
                  idx_d   = idx_dec;
                  probe_d = new_acc | bit_mask;
               end else begin
                  probe_d = new_acc;
                  state_d = VERIFY;
               end
            end
         end
         VERIFY: begin
            result_d = acc_q;
            found_d  = flags_ok & cmp_eq;
            err_d    = ~flags_ok;
            state_d  = DONE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == STEP) || (state_d == VERIFY);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         probe_q  <= '0;
         acc_q    <= '0;
         result_q <= '0;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         found_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         probe_q  <= probe_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         idx_q    <= idx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         found_q  <= found_d;
         err_q    <= err_d;
      end
   end

   assign probe  = probe_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign found  = found_q;
   assign err    = err_q;

endmodule
